// File: rtl/seg_scan_decoder_if.sv
// Seven-segment scan bus between a multiplexed display source and the
// scan decoder.
//   seg_in      : segment lines {G,F,E,D,C,B,A}, active-high
//   an_in       : one-hot digit select, active-high
//   hex_out     : decoded nibbles, digit i at [4i+3:4i]
//   digit_valid : per-digit legal-value flag
//   digit_err   : per-digit illegal-last-capture flag
//   upd_pulse   : one-cycle strobe on every capture
//   upd_idx     : index of the digit captured (held between strobes)
// master = the side driving the segment pins, slave = the decoder.
interface seg_scan_decoder_if #(
  parameter int NUM_DIGITS = 4,
  parameter int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
);
  logic [6:0]              seg_in;
  logic [NUM_DIGITS-1:0]   an_in;
  logic [4*NUM_DIGITS-1:0] hex_out;
  logic [NUM_DIGITS-1:0]   digit_valid;
  logic [NUM_DIGITS-1:0]   digit_err;
  logic                    upd_pulse;
  logic [IDX_W-1:0]        upd_idx;

  modport master (
    output seg_in, an_in,
    input  hex_out, digit_valid, digit_err, upd_pulse, upd_idx
  );

  modport slave (
    input  seg_in, an_in,
    output hex_out, digit_valid, digit_err, upd_pulse, upd_idx
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: samples a multiplexed segment bus, waits for
// STABLE_CYCLES identical samples of {segments, select}, decodes the pattern
// back to a hex nibble and stores it in a per-digit slot with valid/err flags.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : seg_scan_decoder_if slave (pins in, decoded slots out)
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | select not one-hot, nothing to capture
// S_SETTLE | one-hot select, counting identical samples
// S_CAPTURE| single cycle: slot written, upd_pulse high
// S_HOLD   | captured value still on the pins, no re-capture
module seg_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic               clk,
  input  logic               reset,
  seg_scan_decoder_if.slave  bus
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE, S_HOLD} state_t;

  state_t state, state_next, state_eval;

  logic [6:0]              seg_q, seg_prev;
  logic [NUM_DIGITS-1:0]   an_q, an_prev;
  logic [CNT_W-1:0]        cnt, cnt_eff;
  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0]   valid_q, err_q;
  logic [IDX_W-1:0]        idx_q, cap_idx;
  logic                    same, one_hot, capture;
  logic [4:0]              dec;

  // {legal, nibble}
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h3F: decode = 5'h10;
      7'h06: decode = 5'h11;
      7'h5B: decode = 5'h12;
      7'h4F: decode = 5'h13;
      7'h66: decode = 5'h14;
      7'h6D: decode = 5'h15;
      7'h7D: decode = 5'h16;
      7'h07: decode = 5'h17;
      7'h7F: decode = 5'h18;
      7'h67: decode = 5'h19;
      7'h77: decode = 5'h1A;
      7'h7C: decode = 5'h1B;
      7'h39: decode = 5'h1C;
      7'h5E: decode = 5'h1D;
      7'h79: decode = 5'h1E;
      7'h71: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  // cnt_eff is the run length including the sample now in seg_q/an_q, so a
  // capture can be decided on the edge right after the last needed sample.
  always_comb begin
    same    = ({seg_q, an_q} == {seg_prev, an_prev});
    one_hot = (an_q != '0) && ((an_q & (an_q - 1'b1)) == '0);
    if (!same)
      cnt_eff = CNT_W'(1);
    else if (cnt == CNT_MAX)
      cnt_eff = cnt;
    else
      cnt_eff = cnt + CNT_W'(1);
    dec     = decode(seg_q);
    cap_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_q[i]) cap_idx = IDX_W'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A change seen during CAPTURE must be evaluated at once; otherwise the
  // previous-sample register would absorb it and HOLD would never notice.
  always_comb begin
    if (!one_hot)
      state_eval = S_IDLE;
    else if (cnt_eff == CNT_MAX)
      state_eval = S_CAPTURE;
    else
      state_eval = S_SETTLE;
    state_next = state;
    case (state)
      S_IDLE, S_SETTLE:  state_next = state_eval;
      S_CAPTURE, S_HOLD: state_next = same ? S_HOLD : state_eval;
      default:           state_next = S_IDLE;
    endcase
  end

  always_comb begin
    capture       = (state_next == S_CAPTURE);
    bus.upd_pulse = (state == S_CAPTURE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q    <= '0;
      an_q     <= '0;
      seg_prev <= '0;
      an_prev  <= '0;
      cnt      <= '0;
      hex_q    <= '0;
      valid_q  <= '0;
      err_q    <= '0;
      idx_q    <= '0;
    end else begin
      seg_q    <= bus.seg_in;
      an_q     <= bus.an_in;
      seg_prev <= seg_q;
      an_prev  <= an_q;
      cnt      <= cnt_eff;
      if (capture) begin
        idx_q <= cap_idx;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (an_q[i]) begin
            if (dec[4]) begin
              hex_q[4*i +: 4] <= dec[3:0];
              valid_q[i]      <= 1'b1;
              err_q[i]        <= 1'b0;
            end else begin
              // blank clears both flags; any other pattern flags an error
              valid_q[i] <= 1'b0;
              err_q[i]   <= (seg_q != 7'h00);
            end
          end
        end
      end
    end
  end

  assign bus.hex_out     = hex_q;
  assign bus.digit_valid = valid_q;
  assign bus.digit_err   = err_q;
  assign bus.upd_idx     = idx_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;
  localparam int ND = 4;
  localparam int S  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seg_scan_decoder_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          idx;
    logic [15:0] hex;
    logic [3:0]  valid;
    logic [3:0]  err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int checks = 0;
  int passed = 0;
  int pulses = 0;
  int p0;
  logic [15:0] m_hex;
  logic [3:0]  m_valid, m_err;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.upd_pulse === 1'b1) begin
      pulses++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: upd_idx=%0d seg_in=%0h at cycle %0d, none expected",
                 bus.upd_idx, bus.seg_in, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("upd_idx", 32'(bus.upd_idx), 32'(e.idx));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("hex_out", 32'(bus.hex_out), 32'(e.hex));
        check("digit_valid", 32'(bus.digit_valid), 32'(e.valid));
        check("digit_err", 32'(bus.digit_err), 32'(e.err));
      end
    end
  end

  // code: 0..15 legal nibble, 16 blank, 17 illegal, -1 no capture expected
  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n, input int code);
    int idx;
    bus.an_in  = an;
    bus.seg_in = seg;
    if (code >= 0) begin
      case (an)
        4'b0001: idx = 0;
        4'b0010: idx = 1;
        4'b0100: idx = 2;
        default: idx = 3;
      endcase
      if (code < 16) begin
        m_hex[4*idx +: 4] = 4'(code);
        m_valid[idx] = 1'b1;
        m_err[idx]   = 1'b0;
      end else begin
        m_valid[idx] = 1'b0;
        m_err[idx]   = (code == 17);
      end
      q.push_back('{idx, m_hex, m_valid, m_err, cyc + 1 + S});
    end
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.an_in  = '0;
    bus.seg_in = '0;
    m_hex = '0; m_valid = '0; m_err = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", 32'(bus.hex_out), 0);
    check("rst_valid", 32'(bus.digit_valid), 0);
    check("rst_err", 32'(bus.digit_err), 0);
    check("rst_pulse", 32'(bus.upd_pulse), 0);
    reset = 1'b0;

    // single digit
    p0 = pulses;
    drive(4'b0001, 7'h5B, 5, 2);
    repeat (2) @(posedge clk); #1;
    check("t1_nibble", 32'(bus.hex_out[3:0]), 2);
    check("t1_valid", 32'(bus.digit_valid), 4'b0001);
    check("t1_pulses", 32'(pulses - p0), 1);

    // full scan, digit 0 overwritten
    p0 = pulses;
    drive(4'b0001, 7'h3F, 6, 0);
    drive(4'b0010, 7'h06, 6, 1);
    drive(4'b0100, 7'h77, 6, 10);
    drive(4'b1000, 7'h71, 6, 15);
    repeat (2) @(posedge clk); #1;
    check("scan_hex", 32'(bus.hex_out), 16'hFA10);
    check("scan_valid", 32'(bus.digit_valid), 4'b1111);
    check("scan_pulses", 32'(pulses - p0), 4);

    // glitch: 6 for only 3 samples, then 8 for 4
    p0 = pulses;
    drive(4'b0010, 7'h7D, 3, -1);
    drive(4'b0010, 7'h7F, 4, 8);
    repeat (3) @(posedge clk); #1;
    check("glitch_nibble", 32'(bus.hex_out[7:4]), 8);
    check("glitch_pulses", 32'(pulses - p0), 1);

    // legal, illegal, blank on digit 2
    drive(4'b0100, 7'h79, 6, 14);
    check("e_valid", 32'(bus.digit_valid[2]), 1);
    check("e_nibble", 32'(bus.hex_out[11:8]), 4'hE);
    drive(4'b0100, 7'h55, 6, 17);
    check("ill_err", 32'(bus.digit_err[2]), 1);
    check("ill_valid", 32'(bus.digit_valid[2]), 0);
    check("ill_nibble", 32'(bus.hex_out[11:8]), 4'hE);
    drive(4'b0100, 7'h00, 6, 16);
    check("blank_err", 32'(bus.digit_err[2]), 0);
    check("blank_valid", 32'(bus.digit_valid[2]), 0);
    check("blank_nibble", 32'(bus.hex_out[11:8]), 4'hE);

    // non-one-hot selects never capture
    p0 = pulses;
    drive(4'b0011, 7'h06, 10, -1);
    drive(4'b0000, 7'h06, 10, -1);
    check("nohot_pulses", 32'(pulses - p0), 0);
    check("nohot_hex", 32'(bus.hex_out), 32'(m_hex));
    check("nohot_valid", 32'(bus.digit_valid), 32'(m_valid));
    check("nohot_err", 32'(bus.digit_err), 32'(m_err));

    // reset on the would-be capture edge of digit 3
    p0 = pulses;
    drive(4'b1000, 7'h4F, 4, -1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_hex", 32'(bus.hex_out), 0);
    check("mid_rst_valid", 32'(bus.digit_valid), 0);
    check("mid_rst_err", 32'(bus.digit_err), 0);
    check("mid_rst_pulse", 32'(bus.upd_pulse), 0);
    check("mid_rst_idx", 32'(bus.upd_idx), 0);
    m_hex = '0; m_valid = '0; m_err = '0;
    drive(4'b1000, 7'h4F, 8, 3);
    check("rst_cap_pulses", 32'(pulses - p0), 1);

    repeat (3) @(posedge clk); #1;
    check("queue_drained", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Reader-side counterpart to the team's hex-to-seven-segment encoder.
- Samples a multiplexed seven-segment bus: seven segment lines plus a one-hot digit-select.
- Debounces each segment/select combination and decodes the pattern back to a 4-bit hex nibble.
- Keeps a per-digit register file with valid/error flags. Used for display loopback checking and for reading external seven-segment sources.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (≥1).
- STABLE_CYCLES, 4, consecutive identical samples required before capture (≥1).
- CNT_W, 3, width of the stability counter; must hold STABLE_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seg_in  in  7  segment lines {G,F,E,D,C,B,A}; A = bit 0; active-high (1 = lit).
- an_in  in  NUM_DIGITS  digit select, active-high, bit i = digit i.
- hex_out  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i].
- digit_valid  out  NUM_DIGITS  bit i set when digit i holds a legal decoded value.
- digit_err  out  NUM_DIGITS  bit i set when the last capture for digit i was an illegal pattern.
- upd_pulse  out  1  one-cycle strobe on every capture.
- upd_idx  out  $clog2(NUM_DIGITS) (min 1)  index of the digit captured; valid when upd_pulse = 1.

Behaviour:
- Reset: synchronous, active-high, one clk; the interface is decided as one clock with a synchronous active-high reset.
  - Clears seg_q, an_q, counter, hex_out, digit_valid, digit_err, upd_pulse and upd_idx to 0. State becomes IDLE.
  - Reset dominates all other activity. A capture in progress is discarded and no upd_pulse is produced.
- Input stage: seg_in/an_in are registered every cycle into seg_q/an_q. All decisions use the registered values.
- Stability counter:
  - If {seg_q, an_q} equals its value in the previous cycle, the counter increments, saturating at STABLE_CYCLES.
  - Otherwise the counter is set to 1.
- States:
  - IDLE: an_q is not one-hot (zero or multiple bits set). No capture. Leave when an_q is one-hot → SETTLE.
  - SETTLE: on counter == STABLE_CYCLES → CAPTURE. Any change in {seg_q, an_q} restarts counting. A non-one-hot an_q → IDLE.
  - CAPTURE: single cycle. Writes the slot and asserts upd_pulse for that cycle → HOLD.
  - HOLD: no re-capture while inputs remain unchanged. A change → SETTLE (if one-hot) or IDLE.
- Latency: pins stable from edge k onward → upd_pulse high in the cycle after edge k+STABLE_CYCLES. Slot registers update on that same edge.
- Decode table (seg value → nibble):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7
  - 0x7F→8, 0x67→9, 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F
- Capture result for digit i:
  - Legal pattern: write nibble, set valid, clear err.
  - Blank (0x00): clear valid, clear err, nibble unchanged.
  - Any other pattern: set err, clear valid, nibble unchanged.
- Scope of a capture: it affects only the selected digit. Other slots are held.
- Repeated capture of the same digit: overwrites the slot; the last capture wins.
- Boundary conditions:
  - STABLE_CYCLES = 1: capture in the cycle after the first registered sample, if that sample is one-hot.
  - The counter never wraps.
  - upd_idx holds its last value when upd_pulse = 0.

Test Plan:
- Reset → hex_out, digit_valid, digit_err, upd_pulse all 0. Then an_in=0001, seg_in=0x5B held 5 cycles → one upd_pulse with upd_idx=0, hex_out[3:0]=2, digit_valid=0001.
- Scan 4 digits with patterns 0x3F, 0x06, 0x77, 0x71, each held 6 cycles → hex_out=0xFA10, digit_valid=1111, exactly 4 upd_pulses.
- Glitch: an_in=0010, seg_in=0x7D for 3 cycles, then 0x7F for 4 cycles (STABLE_CYCLES=4) → a single capture with hex_out[7:4]=8; 6 is never captured.
- Illegal and blank: digit 2 at 0x79 (E), then 0x55, then 0x00 → E/valid=1, then err=1/valid=0/nibble still E, then err=0/valid=0/nibble still E.
- an_in=0011 or 0000 held 10 cycles with a legal seg_in → no upd_pulse; all slots unchanged.
- Reset asserted at counter=3 during a capture of digit 3, then released → no upd_pulse; all outputs 0. Inputs still stable → capture occurs STABLE_CYCLES+1 edges after release.
